// File: rtl/buffered_async_operator.sv
`default_nettype none
// ============================================================================
// Module      : buffered_async_operator
// Description : Req/ack dataflow operator with a token FIFO on every input
//               channel and independent per-consumer delivery. A firing pops
//               one token from each input, computes f(heads) into dout and
//               marks the result pending for every consumer; each consumer
//               then collects it with its own one-cycle ack_r pulse.
//
// Ports       : clk         clock
//               rst         synchronous active-high reset
//               req_l       per-producer request (registered)
//               ack_l       per-producer one-cycle token strobe
//               din         input tokens, channel i at [DW*(i+1)-1 : DW*i]
//               req_r       per-consumer request
//               ack_r       per-consumer one-cycle delivery strobe (registered)
//               dout        result token, stable while any ack_r bit is high
//               fire_count  firings since reset, wraps at 2^32
//
// Revision    : 1.0  initial release
// ============================================================================
module buffered_async_operator #(
    parameter int                    DATA_WIDTH  = 32,
    parameter string                 OP          = "reg",
    parameter logic [DATA_WIDTH-1:0] IMMEDIATE   = '0,
    parameter int                    INPUT_SIZE  = 1,
    parameter int                    OUTPUT_SIZE = 1,
    parameter int                    FIFO_DEPTH  = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic [INPUT_SIZE-1:0]            req_l,
    input  logic [INPUT_SIZE-1:0]            ack_l,
    input  logic [DATA_WIDTH*INPUT_SIZE-1:0] din,
    input  logic [OUTPUT_SIZE-1:0]           req_r,
    output logic [OUTPUT_SIZE-1:0]           ack_r,
    output logic [DATA_WIDTH-1:0]            dout,
    output logic [31:0]                      fire_count
);

    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(FIFO_DEPTH - 1);

    // Operator encoding, resolved at elaboration time.
    localparam int c_op_pass = 0;
    localparam int c_op_addi = 1;
    localparam int c_op_subi = 2;
    localparam int c_op_muli = 3;
    localparam int c_op_add  = 4;
    localparam int c_op_sub  = 5;
    localparam int c_op_mul  = 6;
    localparam int c_op_and  = 7;
    localparam int c_op_or   = 8;
    localparam int c_op_xor  = 9;
    localparam int c_op_min  = 10;
    localparam int c_op_max  = 11;
    localparam int c_op_bad  = 15;

    localparam int c_op =
        (OP == "reg" || OP == "in" || OP == "out") ? c_op_pass :
        (OP == "addi") ? c_op_addi :
        (OP == "subi") ? c_op_subi :
        (OP == "muli") ? c_op_muli :
        (OP == "add")  ? c_op_add  :
        (OP == "sub")  ? c_op_sub  :
        (OP == "mul")  ? c_op_mul  :
        (OP == "and")  ? c_op_and  :
        (OP == "or")   ? c_op_or   :
        (OP == "xor")  ? c_op_xor  :
        (OP == "min")  ? c_op_min  :
        (OP == "max")  ? c_op_max  : c_op_bad;

    localparam bit c_unary  = (c_op <= c_op_muli);
    localparam bit c_binary = (c_op >= c_op_add) && (c_op <= c_op_max);
    // Operator/arity mismatches still fire and deliver, but the token is 0.
    localparam bit c_legal  = (c_unary && INPUT_SIZE == 1) ||
                              (c_binary && INPUT_SIZE >= 2);

    logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0] w_head;
    logic [INPUT_SIZE-1:0]                 w_nonempty;
    logic [INPUT_SIZE-1:0]                 w_req_next;
    logic [OUTPUT_SIZE-1:0]                w_ack_next;
    logic                                  w_fire;
    logic [DATA_WIDTH-1:0]                 w_acc;
    logic [DATA_WIDTH-1:0]                 w_result;

    logic [INPUT_SIZE-1:0]                 r_req_l;
    logic [OUTPUT_SIZE-1:0]                r_ack_r;
    logic [OUTPUT_SIZE-1:0]                r_pending;
    logic [DATA_WIDTH-1:0]                 r_dout;
    logic [31:0]                           r_fire_count;

    // A new token is only taken once every consumer has collected the
    // previous one and every ack_r pulse has dropped again.
    assign w_fire = (&w_nonempty) & ~(|r_pending) & ~(|r_ack_r);

    // ------------------------------------------------------------------
    // Per-input token FIFOs
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < INPUT_SIZE; gi++) begin : g_chan
        logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
        logic [c_ptr_w-1:0]    r_wr_ptr;
        logic [c_ptr_w-1:0]    r_rd_ptr;
        logic [c_cnt_w-1:0]    r_cnt;
        logic                  w_push;
        logic                  w_pop;
        logic [c_cnt_w-1:0]    w_cnt_next;

        // A strobe arriving while full is a producer protocol error; the
        // token is dropped rather than corrupting the queue.
        assign w_push     = ack_l[gi] & (r_cnt < c_depth);
        assign w_pop      = w_fire;
        assign w_cnt_next = r_cnt + c_cnt_w'(w_push) - c_cnt_w'(w_pop);

        assign w_head[gi]     = r_mem[r_rd_ptr];
        assign w_nonempty[gi] = (r_cnt != '0);
        // Request is withheld for the cycle after every strobe, so the
        // producer never has more than one token in flight.
        assign w_req_next[gi] = ~ack_l[gi] & (w_cnt_next < c_depth);

        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din[DATA_WIDTH*gi +: DATA_WIDTH];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_cnt    <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + c_ptr_w'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + c_ptr_w'(1);
                end
                r_cnt <= w_cnt_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Operator datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_acc = w_head[0];
        for (int i = 1; i < INPUT_SIZE; i++) begin
            case (c_op)
                c_op_add: w_acc = w_acc + w_head[i];
                c_op_sub: w_acc = w_acc - w_head[i];
                c_op_mul: w_acc = w_acc * w_head[i];
                c_op_and: w_acc = w_acc & w_head[i];
                c_op_or:  w_acc = w_acc | w_head[i];
                c_op_xor: w_acc = w_acc ^ w_head[i];
                c_op_min: if (w_head[i] < w_acc) w_acc = w_head[i];
                c_op_max: if (w_head[i] > w_acc) w_acc = w_head[i];
                default:  w_acc = w_acc;
            endcase
        end

        w_result = '0;
        if (c_legal) begin
            case (c_op)
                c_op_pass: w_result = w_head[0];
                c_op_addi: w_result = w_head[0] + IMMEDIATE;
                c_op_subi: w_result = w_head[0] - IMMEDIATE;
                c_op_muli: w_result = w_head[0] * IMMEDIATE;
                default:   w_result = w_acc;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Fan-out delivery: each consumer gets a single pulse per token, and
    // the pulse always drops for a cycle before the next one can rise.
    // ------------------------------------------------------------------
    assign w_ack_next = r_pending & req_r & ~r_ack_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_l      <= '0;
            r_ack_r      <= '0;
            r_pending    <= '0;
            r_dout       <= '0;
            r_fire_count <= '0;
        end else begin
            r_req_l   <= w_req_next;
            r_ack_r   <= w_ack_next;
            // Firing requires pending==0, so it never races a clear.
            r_pending <= w_fire ? '1 : (r_pending & ~w_ack_next);
            if (w_fire) begin
                r_dout       <= w_result;
                r_fire_count <= r_fire_count + 32'd1;
            end
        end
    end

    assign req_l      = r_req_l;
    assign ack_r      = r_ack_r;
    assign dout       = r_dout;
    assign fire_count = r_fire_count;

endmodule
`default_nettype wire

// File: tb/tb_buffered_async_operator.sv
`default_nettype none
// ============================================================================
// Module      : tb_buffered_async_operator
// Description : Scoreboard bench. A 2-input, 3-consumer "add" node carries
//               the streaming traffic; three single-shot nodes cover sub,
//               muli wrap-around and an illegal operator/arity pairing.
//               Expected results are queued when tokens are handed to the
//               producer model; monitors pop and compare on every ack_r.
// Revision    : 1.0  initial release
// ============================================================================
module tb_buffered_async_operator;

    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Main node: add, 2 inputs, 3 consumers, depth 2
    logic [1:0]      req_l, ack_l;
    logic [2*DW-1:0] din;
    logic [2:0]      req_r, ack_r;
    logic [DW-1:0]   dout;
    logic [31:0]     fire_count;

    // sub node, 3 inputs
    logic [2:0]      s_req_l, s_ack_l;
    logic [3*DW-1:0] s_din;
    logic            s_ack_r;
    logic [DW-1:0]   s_dout;
    logic [31:0]     s_fc;

    // muli node, immediate 3
    logic            m_req_l, m_ack_l;
    logic [DW-1:0]   m_din;
    logic            m_ack_r;
    logic [DW-1:0]   m_dout;
    logic [31:0]     m_fc;

    // add with a single input: illegal pairing
    logic            b_req_l, b_ack_l;
    logic [DW-1:0]   b_din;
    logic            b_ack_r;
    logic [DW-1:0]   b_dout;
    logic [31:0]     b_fc;

    buffered_async_operator #(
        .DATA_WIDTH(DW), .OP("add"), .IMMEDIATE('0),
        .INPUT_SIZE(2), .OUTPUT_SIZE(3), .FIFO_DEPTH(2)
    ) u_dut (
        .clk(clk), .rst(rst), .req_l(req_l), .ack_l(ack_l), .din(din),
        .req_r(req_r), .ack_r(ack_r), .dout(dout), .fire_count(fire_count)
    );

    buffered_async_operator #(
        .DATA_WIDTH(DW), .OP("sub"), .IMMEDIATE('0),
        .INPUT_SIZE(3), .OUTPUT_SIZE(1), .FIFO_DEPTH(2)
    ) u_sub (
        .clk(clk), .rst(rst), .req_l(s_req_l), .ack_l(s_ack_l), .din(s_din),
        .req_r(1'b1), .ack_r(s_ack_r), .dout(s_dout), .fire_count(s_fc)
    );

    buffered_async_operator #(
        .DATA_WIDTH(DW), .OP("muli"), .IMMEDIATE(32'd3),
        .INPUT_SIZE(1), .OUTPUT_SIZE(1), .FIFO_DEPTH(2)
    ) u_mul (
        .clk(clk), .rst(rst), .req_l(m_req_l), .ack_l(m_ack_l), .din(m_din),
        .req_r(1'b1), .ack_r(m_ack_r), .dout(m_dout), .fire_count(m_fc)
    );

    buffered_async_operator #(
        .DATA_WIDTH(DW), .OP("add"), .IMMEDIATE('0),
        .INPUT_SIZE(1), .OUTPUT_SIZE(1), .FIFO_DEPTH(2)
    ) u_bad (
        .clk(clk), .rst(rst), .req_l(b_req_l), .ack_l(b_ack_l), .din(b_din),
        .req_r(1'b1), .ack_r(b_ack_r), .dout(b_dout), .fire_count(b_fc)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] src0[$], src1[$];
    logic [DW-1:0] exp0[$], exp1[$], exp2[$];
    logic [DW-1:0] exp_s[$], exp_m[$], exp_b[$];

    int         p_stall = 0;
    int         c_stall = 0;
    logic [2:0] c_en    = 3'b111;
    logic       inject  = 1'b0;
    int         efc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // ---------------- producer model (with occupancy tracking) ----------
    int         occ0 = 0, occ1 = 0;
    logic [1:0] prev_ack = '0;
    logic       prev_rst = 1'b1;
    logic [31:0] last_fc = '0;

    always @(negedge clk) begin
        logic fired;
        fired   = (fire_count != last_fc);
        last_fc = fire_count;
        if (prev_rst) begin
            occ0 = 0;
            occ1 = 0;
        end else begin
            occ0 = occ0 + int'(prev_ack[0]) - int'(fired);
            occ1 = occ1 + int'(prev_ack[1]) - int'(fired);
        end
        prev_rst = rst;

        ack_l = '0;
        if (inject) begin
            ack_l = 2'b11;
            din   = {32'd99, 32'd99};
        end else begin
            if (req_l[0] && src0.size() > 0 && $urandom_range(0, 99) >= p_stall) begin
                checks++;
                if (occ0 >= 2) begin
                    errors++;
                    $display("FAIL overflow_ch0: occupancy %0d required below 2", occ0);
                end
                ack_l[0]     = 1'b1;
                din[DW-1:0]  = src0.pop_front();
            end
            if (req_l[1] && src1.size() > 0 && $urandom_range(0, 99) >= p_stall) begin
                checks++;
                if (occ1 >= 2) begin
                    errors++;
                    $display("FAIL overflow_ch1: occupancy %0d required below 2", occ1);
                end
                ack_l[1]       = 1'b1;
                din[2*DW-1:DW] = src1.pop_front();
            end
        end
        prev_ack = ack_l;
    end

    // ---------------- consumer model ------------------------------------
    always @(negedge clk) begin
        for (int j = 0; j < 3; j++) begin
            req_r[j] = c_en[j] && ($urandom_range(0, 99) >= c_stall);
        end
    end

    // ---------------- monitors ------------------------------------------
    always @(negedge clk) begin
        if (!rst) begin
            if (ack_r[0]) begin
                if (exp0.size() == 0) flag("c0_unexpected_ack");
                else check("c0_dout", dout, exp0.pop_front());
            end
            if (ack_r[1]) begin
                if (exp1.size() == 0) flag("c1_unexpected_ack");
                else check("c1_dout", dout, exp1.pop_front());
            end
            if (ack_r[2]) begin
                if (exp2.size() == 0) flag("c2_unexpected_ack");
                else check("c2_dout", dout, exp2.pop_front());
            end
            if (s_ack_r) begin
                if (exp_s.size() == 0) flag("sub_unexpected_ack");
                else check("sub_dout", s_dout, exp_s.pop_front());
            end
            if (m_ack_r) begin
                if (exp_m.size() == 0) flag("muli_unexpected_ack");
                else check("muli_dout", m_dout, exp_m.pop_front());
            end
            if (b_ack_r) begin
                if (exp_b.size() == 0) flag("illegal_unexpected_ack");
                else check("illegal_dout", b_dout, exp_b.pop_front());
            end
        end
    end

    // ---------------- helpers -------------------------------------------
    task automatic load(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] sum;
        sum = a + b;
        src0.push_back(a);
        src1.push_back(b);
        exp0.push_back(sum);
        exp1.push_back(sum);
        exp2.push_back(sum);
        efc++;
    endtask

    function automatic int outstanding();
        return src0.size() + src1.size() + exp0.size() + exp1.size() + exp2.size()
             + exp_s.size() + exp_m.size() + exp_b.size();
    endfunction

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (outstanding() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #2;
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: %0d tokens outstanding after %0d cycles", name, outstanding(), budget);
        end
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic wait_fc(input string name, input logic [31:0] target, input int budget);
        int n;
        n = 0;
        while (fire_count != target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #2;
        check(name, fire_count, target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus ------------------------------------------
    initial begin
        int base;
        rst     = 1'b1;
        s_ack_l = '0; s_din = '0;
        m_ack_l = 1'b0; m_din = '0;
        b_ack_l = 1'b0; b_din = '0;
        repeat (3) @(posedge clk);
        #2;

        // Reset state
        check("reset_ack_r", {29'd0, ack_r}, 32'd0);
        check("reset_dout", dout, 32'd0);
        check("reset_fire_count", fire_count, 32'd0);
        check("reset_req_l", {30'd0, req_l}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #2;
        check("req_l_after_reset", {30'd0, req_l}, 32'd3);

        // T1: 5 + 7 -> 12, delivered once to every consumer
        load(32'd5, 32'd7);
        drain("t1_drain", 100);
        check("t1_fire_count", fire_count, 32'(efc));

        // T2: sub 20-3-4, muli wrap, illegal add with one input
        check("sub_req_l_idle", {29'd0, s_req_l}, 32'd7);
        s_ack_l = 3'b111;
        s_din   = {32'd4, 32'd3, 32'd20};
        m_ack_l = 1'b1;
        m_din   = 32'h8000_0001;
        b_ack_l = 1'b1;
        b_din   = 32'd5;
        exp_s.push_back(32'd13);
        exp_m.push_back(32'h8000_0003);
        exp_b.push_back(32'd0);
        @(posedge clk);
        #2;
        check("sub_req_l_drop", {29'd0, s_req_l}, 32'd0);
        check("muli_req_l_drop", {31'd0, m_req_l}, 32'd0);
        s_ack_l = '0;
        m_ack_l = 1'b0;
        b_ack_l = 1'b0;
        drain("t2_drain", 50);
        check("sub_fire_count", s_fc, 32'd1);

        // T3: consumers stalled, producers free-running, then 5000 in order
        c_en = 3'b000;
        base = efc;
        for (int k = 0; k < 5000; k++) load(32'(k), 32'd0);
        repeat (30) @(posedge clk);
        #2;
        check("t3_req_l_backpressure", {30'd0, req_l}, 32'd0);
        check("t3_single_fire", fire_count, 32'(base + 1));
        c_en = 3'b111;
        drain("t3_drain", 30000);
        check("t3_fire_count", fire_count, 32'(efc));

        // T4: consumer 2 late; second token must wait for its ack
        c_en = 3'b011;
        base = efc;
        load(32'd1, 32'd1);
        load(32'd2, 32'd2);
        repeat (10) @(posedge clk);
        #2;
        check("t4_blocked_by_c2", fire_count, 32'(base + 1));
        c_en = 3'b111;
        wait_fc("t4_second_fire", 32'(base + 2), 40);
        drain("t4_drain", 100);

        // T5: reset with two tokens buffered and pending=101
        c_en = 3'b010;
        base = efc;
        load(32'd10, 32'd10);
        load(32'd20, 32'd20);
        load(32'd30, 32'd30);
        repeat (15) @(posedge clk);
        #2;
        check("t5_pre_reset_fires", fire_count, 32'(base + 1));
        rst    = 1'b1;
        inject = 1'b1;
        @(posedge clk);
        #2;
        rst    = 1'b0;
        inject = 1'b0;
        check("t5_ack_r", {29'd0, ack_r}, 32'd0);
        check("t5_dout", dout, 32'd0);
        check("t5_fire_count", fire_count, 32'd0);
        check("t5_req_l", {30'd0, req_l}, 32'd0);
        src0.delete(); src1.delete();
        exp0.delete(); exp1.delete(); exp2.delete();
        efc  = 0;
        c_en = 3'b111;
        load(32'd1, 32'd2);
        drain("t5_drain", 100);
        check("t5_post_fire_count", fire_count, 32'(efc));

        // T6: random 30% stalls on both sides
        p_stall = 30;
        c_stall = 30;
        for (int k = 0; k < 400; k++) load(32'(k * 3 + 1), 32'(k * 5 + 2));
        drain("t6_drain", 20000);
        check("t6_fire_count", fire_count, 32'(efc));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
